// File: rtl/pingpong_buffer_reader.sv
`default_nettype none
// ============================================================================
// Module      : pingpong_buffer_reader
// Description : Consumer side of a ping-pong RAM pair. Waits for the writer to
//               mark a bank full, reads it word by word and presents each word
//               on a valid/ready stream, then hands the bank back. Banks are
//               drained strictly alternately (RAM1, RAM2, RAM1, ...).
//               Optional saturating overrun counter: PINGPONG_RD_OVERRUN_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pingpong_buffer_reader #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fill_done,
    input  logic              fill_bank,
    output logic              ram1_read_en,
    output logic [ADDR_W-1:0] ram1_read_address,
    input  logic [DATA_W-1:0] ram1_read,
    output logic              ram2_read_en,
    output logic [ADDR_W-1:0] ram2_read_address,
    input  logic [DATA_W-1:0] ram2_read,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              bank_release,
    output logic              release_bank,
    output logic              overrun,
    output logic [7:0]        overrun_count
);

    localparam logic [ADDR_W-1:0] C_LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_CAPT    = 3'd2,
        ST_HOLD    = 3'd3,
        ST_RELEASE = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [1:0]          r_full;
    logic [1:0]          w_full_next;
    logic                r_expected;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_out_data;
    logic                r_out_valid;
    logic                r_overrun;
    logic                w_transfer;
    logic                w_clear;
    logic                w_overrun_evt;

    assign w_transfer = r_out_valid & out_ready;
    assign out_data   = r_out_data;
    assign out_valid  = r_out_valid;
    assign overrun    = r_overrun;

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    // Next-state decode and RAM/release strobes derived from the current state
    always_comb begin
        w_state_next      = r_state;
        ram1_read_en      = 1'b0;
        ram2_read_en      = 1'b0;
        ram1_read_address = '0;
        ram2_read_address = '0;
        bank_release      = 1'b0;
        release_bank      = 1'b0;
        w_clear           = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_full[r_expected]) w_state_next = ST_REQ;
            end
            ST_REQ: begin
                if (r_expected) begin
                    ram2_read_en      = 1'b1;
                    ram2_read_address = r_addr;
                end else begin
                    ram1_read_en      = 1'b1;
                    ram1_read_address = r_addr;
                end
                w_state_next = ST_CAPT;
            end
            ST_CAPT: begin
                w_state_next = ST_HOLD;
            end
            ST_HOLD: begin
                if (w_transfer)
                    w_state_next = (r_addr == C_LAST_ADDR) ? ST_RELEASE : ST_REQ;
            end
            ST_RELEASE: begin
                bank_release = 1'b1;
                release_bank = r_expected;
                w_clear      = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Full-flag update: a set from the writer wins over a same-cycle release
    always_comb begin
        w_full_next = r_full;
        if (w_clear)   w_full_next[r_expected] = 1'b0;
        if (fill_done) w_full_next[fill_bank]  = 1'b1;
    end

    // An overrun is a fill of a bank still marked full and not being released now
    assign w_overrun_evt = fill_done & r_full[fill_bank]
                         & ~(w_clear & (r_expected == fill_bank));

    // Full flags and sticky overrun flag
    always_ff @(posedge clk) begin
        if (reset) begin
            r_full    <= 2'b00;
            r_overrun <= 1'b0;
        end else begin
            r_full <= w_full_next;
            if (w_overrun_evt) r_overrun <= 1'b1;
        end
    end

    // Read address, bank pointer and output stream register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr      <= '0;
            r_expected  <= 1'b0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_full[r_expected]) r_addr <= '0;
                end
                ST_CAPT: begin
                    r_out_data  <= r_expected ? ram2_read : ram1_read;
                    r_out_valid <= 1'b1;
                end
                ST_HOLD: begin
                    if (w_transfer) begin
                        r_out_valid <= 1'b0;
                        if (r_addr != C_LAST_ADDR) r_addr <= r_addr + ADDR_W'(1);
                    end
                end
                ST_RELEASE: begin
                    r_expected <= ~r_expected;
                    r_addr     <= '0;
                end
                default: ;
            endcase
        end
    end

`ifdef PINGPONG_RD_OVERRUN_CNT_EN
    logic [7:0] r_overrun_count;

    // Saturating count of overrun events
    always_ff @(posedge clk) begin
        if (reset)
            r_overrun_count <= 8'd0;
        else if (w_overrun_evt && (r_overrun_count != 8'hFF))
            r_overrun_count <= r_overrun_count + 8'd1;
    end

    assign overrun_count = r_overrun_count;
`else
    assign overrun_count = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pingpong_buffer_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_pingpong_buffer_reader
// Description : Directed, scoreboard-based bench for pingpong_buffer_reader.
//               Expected words and release pulses are queued when fills are
//               driven and popped as the reader delivers them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pingpong_buffer_reader;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 32;
`ifdef PINGPONG_RD_OVERRUN_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              fill_done = 1'b0;
    logic              fill_bank = 1'b0;
    logic              ram1_read_en;
    logic [ADDR_W-1:0] ram1_read_address;
    logic [DATA_W-1:0] ram1_read = '0;
    logic              ram2_read_en;
    logic [ADDR_W-1:0] ram2_read_address;
    logic [DATA_W-1:0] ram2_read = '0;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic              bank_release;
    logic              release_bank;
    logic              overrun;
    logic [7:0]        overrun_count;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int delivered = 0;
    bit forbid_rd = 1'b0;
    bit forbid_r2 = 1'b0;
    bit forbid_valid = 1'b0;

    logic [7:0] wq[$];
    logic       rq[$];

    always #5 clk = ~clk;

    pingpong_buffer_reader #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .fill_done(fill_done), .fill_bank(fill_bank),
        .ram1_read_en(ram1_read_en), .ram1_read_address(ram1_read_address),
        .ram1_read(ram1_read),
        .ram2_read_en(ram2_read_en), .ram2_read_address(ram2_read_address),
        .ram2_read(ram2_read),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .bank_release(bank_release), .release_bank(release_bank),
        .overrun(overrun), .overrun_count(overrun_count)
    );

    // RAM models: contents are addr+0x10 (RAM1) and addr+0x80 (RAM2), one-cycle read
    always @(posedge clk) begin
        ram1_read <= {3'b000, ram1_read_address} + 8'h10;
        ram2_read <= {3'b000, ram2_read_address} + 8'h80;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Per-cycle observation of the DUT outputs against the scoreboard
    task automatic monitor();
        logic got;
        if (out_valid && out_ready) begin
            got = (wq.size() != 0);
            check("word_expected", 32'(got), 32'd1);
            if (got) begin
                check("word", 32'(out_data), 32'(wq.pop_front()));
                delivered++;
            end
        end
        if (bank_release) begin
            got = (rq.size() != 0);
            check("release_expected", 32'(got), 32'd1);
            if (got) check("release_bank", 32'(release_bank), 32'(rq.pop_front()));
        end
        check("rd_en_exclusive", 32'(ram1_read_en & ram2_read_en), 32'd0);
        if (!ram1_read_en) check("ram1_addr_idle", 32'(ram1_read_address), 32'd0);
        if (!ram2_read_en) check("ram2_addr_idle", 32'(ram2_read_address), 32'd0);
        if (forbid_rd)    check("no_read", 32'(ram1_read_en | ram2_read_en), 32'd0);
        if (forbid_r2)    check("no_ram2_read", 32'(ram2_read_en), 32'd0);
        if (forbid_valid) check("no_valid", 32'(out_valid), 32'd0);
    endtask

    task automatic step();
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic b);
        fill_done = 1'b1;
        fill_bank = b;
        step();
        fill_done = 1'b0;
    endtask

    task automatic push_bank(input logic b);
        for (int i = 0; i < DEPTH; i++)
            wq.push_back(b ? 8'(i + 8'h80) : 8'(i + 8'h10));
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((wq.size() != 0 || rq.size() != 0) && n < budget) begin
            step();
            n++;
        end
        check("drain_done", 32'(wq.size() + rq.size()), 32'd0);
    endtask

    task automatic do_reset();
        wq.delete();
        rq.delete();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_ram1_en"},   32'(ram1_read_en), 32'd0);
        check({tag, "_ram2_en"},   32'(ram2_read_en), 32'd0);
        check({tag, "_ram1_addr"}, 32'(ram1_read_address), 32'd0);
        check({tag, "_ram2_addr"}, 32'(ram2_read_address), 32'd0);
        check({tag, "_out_data"},  32'(out_data), 32'd0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_release"},   32'(bank_release), 32'd0);
        check({tag, "_rel_bank"},  32'(release_bank), 32'd0);
        check({tag, "_overrun"},   32'(overrun), 32'd0);
        check({tag, "_ov_count"},  32'(overrun_count), 32'd0);
    endtask

    // Directed test sequence
    initial begin
        int n;
        bit stalled;
        logic [7:0] d0;

        // Reset state
        do_reset();
        check_zero_outputs("reset");

        // Single bank0 drain with latency check; RAM2 must stay untouched
        forbid_r2 = 1'b1;
        fill(1'b0);
        push_bank(1'b0);
        rq.push_back(1'b0);
        n = 0;
        while (!out_valid && n < 10) begin
            step();
            n++;
        end
        check("first_valid_latency", 32'(n), 32'd3);
        drain(200);
        forbid_r2 = 1'b0;

        // Back-to-back fills bank0 then bank1
        do_reset();
        fill(1'b0);
        fill(1'b1);
        push_bank(1'b0);
        push_bank(1'b1);
        rq.push_back(1'b0);
        rq.push_back(1'b1);
        drain(400);

        // Bank1 full first must wait for bank0 (strict alternation)
        forbid_rd = 1'b1;
        forbid_valid = 1'b1;
        fill(1'b1);
        repeat (200) step();
        forbid_rd = 1'b0;
        forbid_valid = 1'b0;
        fill(1'b0);
        push_bank(1'b0);
        push_bank(1'b1);
        rq.push_back(1'b0);
        rq.push_back(1'b1);
        drain(400);

        // Backpressure for 10 cycles on word 5
        fill(1'b0);
        push_bank(1'b0);
        rq.push_back(1'b0);
        delivered = 0;
        stalled = 1'b0;
        n = 0;
        while ((wq.size() != 0 || rq.size() != 0) && n < 400) begin
            if (!stalled && out_valid && delivered == 5) begin
                d0 = out_data;
                out_ready = 1'b0;
                forbid_rd = 1'b1;
                repeat (10) begin
                    step();
                    check("stall_valid", 32'(out_valid), 32'd1);
                    check("stall_data", 32'(out_data), 32'(d0));
                end
                out_ready = 1'b1;
                forbid_rd = 1'b0;
                stalled = 1'b1;
            end
            step();
            n++;
        end
        check("stall_seen", 32'(stalled), 32'd1);
        check("drain_done_bp", 32'(wq.size() + rq.size()), 32'd0);

        // Overrun: double fill of bank0, then 300 repeats while bank1 is expected
        do_reset();
        check("overrun_clear", 32'(overrun), 32'd0);
        fill(1'b0);
        fill(1'b0);
        check("overrun_set", 32'(overrun), 32'd1);
        check("overrun_count_1", 32'(overrun_count), CNT_EN ? 32'd1 : 32'd0);
        push_bank(1'b0);
        rq.push_back(1'b0);
        drain(200);
        check("overrun_sticky", 32'(overrun), 32'd1);
        forbid_rd = 1'b1;
        repeat (300) fill(1'b0);
        forbid_rd = 1'b0;
        check("overrun_count_sat", 32'(overrun_count), CNT_EN ? 32'd255 : 32'd0);
        check("overrun_sticky2", 32'(overrun), 32'd1);

        // Reset while holding word 12, then restart from address 0
        do_reset();
        fill(1'b0);
        push_bank(1'b0);
        delivered = 0;
        n = 0;
        while (delivered < 12 && n < 200) begin
            step();
            n++;
        end
        out_ready = 1'b0;
        n = 0;
        while (!out_valid && n < 10) begin
            step();
            n++;
        end
        check("hold_word12", 32'(out_data), 32'h1C);
        wq.delete();
        reset = 1'b1;
        step();
        check_zero_outputs("midreset");
        reset = 1'b0;
        out_ready = 1'b1;
        fill(1'b0);
        push_bank(1'b0);
        rq.push_back(1'b0);
        drain(200);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pingpong_buffer_reader.md
Name: pingpong_buffer_reader

Overview:
- Consumer side of the double-buffered (ping-pong) RAM pair.
- Waits until the writer side marks a bank full, then reads that bank word by word through the RAM read ports.
- Presents each word on a valid/ready output stream, then hands the emptied bank back to the writer.
- Banks are drained strictly alternately: RAM1, RAM2, RAM1, ...

Parameters:
- ADDR_W, 5, width of the RAM read address.
- DATA_W, 8, RAM word and output stream width.
- DEPTH, 32, words per bank; legal range 1..2^ADDR_W.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- fill_done  input  1  one-cycle pulse from writer: the bank in fill_bank is now full.
- fill_bank  input  1  bank completed by the writer (0 = RAM1, 1 = RAM2); sampled only when fill_done=1.
- ram1_read_en  output  1  read enable for RAM1.
- ram1_read_address  output  ADDR_W  read address for RAM1.
- ram1_read  input  DATA_W  RAM1 read data; valid the cycle after ram1_read_en.
- ram2_read_en  output  1  read enable for RAM2.
- ram2_read_address  output  ADDR_W  read address for RAM2.
- ram2_read  input  DATA_W  RAM2 read data; valid the cycle after ram2_read_en.
- out_data  output  DATA_W  stream data.
- out_valid  output  1  out_data holds a valid word.
- out_ready  input  1  downstream accepts; a transfer occurs when out_valid & out_ready.
- bank_release  output  1  one-cycle pulse: the bank in release_bank is empty and writable.
- release_bank  output  1  bank being released; meaningful only when bank_release=1.
- overrun  output  1  sticky error: fill_done arrived for a bank already marked full.
- overrun_count  output  8  saturating overrun event count (optional feature).

Behaviour:
- Reset: all outputs 0, full flags [1:0]=0, expected bank=0, address counter=0, state=IDLE. Reset mid-drain aborts the drain; no release pulse is issued.
- Full flags: fill_done sets full[fill_bank].
  - If full[fill_bank] is already 1: overrun<=1 (sticky until reset) and the flag stays 1.
  - Clearing happens only at RELEASE.
  - A set and a clear of the same bank in the same cycle: the set wins and no overrun is raised.
- States:
  - IDLE: if full[expected]=1, go to REQ with addr=0. Otherwise stay.
  - REQ: assert read_en of the expected bank for exactly one cycle; that bank's address=addr; the other bank's enable is 0. Go to CAPT.
  - CAPT: register the selected bank's read data into out_data; out_valid<=1. Go to HOLD.
  - HOLD: out_valid=1 and out_data held stable until out_ready=1.
    - On transfer, out_valid<=0.
    - If addr==DEPTH-1, go to RELEASE. Else addr<=addr+1 and go to REQ.
  - RELEASE: bank_release=1 for one cycle; release_bank=expected; full[expected]<=0; expected<=~expected; addr<=0. Go to IDLE.
- Read addresses are driven as 0 whenever the bank is not being read.
- Throughput: at most one word per 3 cycles (REQ, CAPT, HOLD with ready already high). Each bank costs 3*DEPTH+1 cycles minimum from leaving IDLE to the release pulse.
- Latency: the first out_valid is asserted 3 cycles after fill_done for the expected bank, given IDLE and no backpressure (fill_done edge sets the flag, then IDLE, REQ, CAPT).
- If the non-expected bank is full first, wait: strict alternation, no skipping.
- If out_ready is held low indefinitely, stay in HOLD; no reads are issued.
- Address never exceeds DEPTH-1; no wrap within a bank.

Optional Feature:
- Macro PINGPONG_RD_OVERRUN_CNT_EN.
- Defined: overrun_count increments on each overrun event and saturates at 255; cleared only by reset.
- Undefined: overrun_count tied to 0 and no counter logic is built; the sticky overrun flag works in both builds.

Test Plan:
- fill_done with fill_bank=0, DEPTH=32, RAM1 preloaded with addr+8'h10, out_ready=1 -> 32 words 8'h10..8'h2F in order on out_data; ram2_read_en never 1; one bank_release with release_bank=0; full[0] cleared.
- Back-to-back fills, bank0 then bank1 (RAM2 = addr+8'h80) -> 64 words, 8'h10..8'h2F then 8'h80..8'h9F; releases for bank 0 then bank 1; next drain starts on RAM1.
- fill_done for bank1 only -> no read_en asserted and no out_valid for 200 cycles; then fill_done for bank0 -> bank0 drained first, then bank1.
- out_ready low for 10 cycles on word 5 -> out_valid stays 1, out_data stable, no extra read_en; all 32 words delivered with no loss or duplication.
- fill_done for bank0 twice before the drain completes -> overrun=1 and stays set; with PINGPONG_RD_OVERRUN_CNT_EN, overrun_count=1; after 300 repeats it reads 255.
- reset asserted in HOLD at word 12 -> next cycle all outputs 0 and state IDLE; a new fill_done for bank0 restarts the drain at address 0.
